// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result collector: unit tags, entry layout, counter width.
package alu_pkg;

  localparam int DATA_W     = 32;
  localparam int DROP_CNT_W = 4;

  localparam logic [1:0] TAG_ARITH = 2'b00;
  localparam logic [1:0] TAG_LOGIC = 2'b01;
  localparam logic [1:0] TAG_CMP   = 2'b10;
  localparam logic [1:0] TAG_SHIFT = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        tag;
    logic              carry;
  } entry_t;

endpackage

// File: rtl/result_fifo.sv
// Register-based synchronous FIFO; a pop in the same cycle frees room for a push when full.
module result_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/alu_result_collector.sv
// Captures one ALU unit result per cycle (fixed priority), buffers it, and tracks drop/collision errors.
module alu_result_collector
  import alu_pkg::*;
#(
  parameter int in_data_width        = 16,
  parameter int arith_out_data_width = DATA_W,
  parameter int fifo_depth           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            arith_flag,
  input  logic                            logic_flag,
  input  logic                            cmp_flag,
  input  logic                            shift_flag,
  input  logic                            carry_out,
  input  logic [arith_out_data_width-1:0] arith_out,
  input  logic [in_data_width-1:0]        logic_out,
  input  logic [in_data_width-1:0]        cmp_out,
  input  logic [in_data_width-1:0]        shift_out,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [arith_out_data_width-1:0] res_data,
  output logic [1:0]                      res_tag,
  output logic                            res_carry,
  output logic                            ovf_err,
  output logic                            col_err,
  output logic [DROP_CNT_W-1:0]           drop_cnt,
  input  logic                            err_clr
);
  localparam int AW  = arith_out_data_width;
  localparam int IW  = in_data_width;
  localparam int EW  = AW + 3;

  logic [EW-1:0] new_entry, head;
  logic [AW-1:0] sel_data;
  logic [1:0]    sel_tag;
  logic          sel_carry;
  logic [2:0]    nflags;
  logic          any_flag, collide, full, empty, pop, drop;

  assign nflags   = {2'b0, arith_flag} + {2'b0, logic_flag} + {2'b0, cmp_flag} + {2'b0, shift_flag};
  assign any_flag = (nflags != 3'd0);
  assign collide  = (nflags > 3'd1);

  always_comb begin
    sel_data  = '0;
    sel_tag   = TAG_ARITH;
    sel_carry = 1'b0;
    if (arith_flag) begin
      sel_data  = arith_out;
      sel_carry = carry_out;
    end else if (logic_flag) begin
      sel_data = {{(AW-IW){1'b0}}, logic_out};
      sel_tag  = TAG_LOGIC;
    end else if (cmp_flag) begin
      sel_data = {{(AW-IW){1'b0}}, cmp_out};
      sel_tag  = TAG_CMP;
    end else if (shift_flag) begin
      sel_data = {{(AW-IW){shift_out[IW-1]}}, shift_out};
      sel_tag  = TAG_SHIFT;
    end
  end

  assign new_entry = {sel_data, sel_tag, sel_carry};
  assign pop       = res_valid && res_ready;
  assign drop      = any_flag && full && !pop;

  result_fifo #(.W(EW), .DEPTH(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (any_flag),
    .pop   (pop),
    .din   (new_entry),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Outputs forced to zero while empty so nothing stale is ever presented.
  assign res_valid = !empty;
  assign res_data  = empty ? '0   : head[EW-1:3];
  assign res_tag   = empty ? 2'b0 : head[2:1];
  assign res_carry = empty ? 1'b0 : head[0];

  // A new error in the same cycle as err_clr takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err  <= 1'b0;
      col_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)         ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
      if (collide)      col_err <= 1'b1;
      else if (err_clr) col_err <= 1'b0;
      if (drop) begin
        if (err_clr)                drop_cnt <= DROP_CNT_W'(1);
        else if (drop_cnt != '1)    drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end else if (err_clr) begin
        drop_cnt <= '0;
      end
    end
  end
endmodule
